param_mem: RTL and testbench
============================

# param_mem

Parametrised single-port synchronous memory: the next-generation DUT for the memory bench, driven through the team's memory interface. It generalises the fixed 4×8 memory to configurable address width, data width, depth and read latency. It adds byte-write strobes, a selectable read-during-write mode, an out-of-range error flag and a self-clearing initialisation sequence after reset.

## Interface

Parameters:
- ADDR_W, default 2: address width.
- DATA_W, default 8: data width; must be a multiple of 8.
- DEPTH, default 4: number of words, 1 ≤ DEPTH ≤ 2**ADDR_W.
- RD_LAT, default 1: read latency in cycles, 1..4.
- RDW_MODE, default READ_FIRST: read-during-write to the same address returns old data (READ_FIRST) or new data (WRITE_FIRST).

Ports:
- clk, in, 1: single clock; all logic on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- addr, in, ADDR_W: word address for read and/or write.
- wr_en, in, 1: write request.
- rd_en, in, 1: read request.
- wstrb, in, DATA_W/8: byte write enables; bit i covers wdata[8i+7:8i].
- wdata, in, DATA_W: write data.
- rdata, out, DATA_W: read data, meaningful only while rvalid=1.
- rvalid, out, 1: rdata valid strobe, one cycle per accepted read.
- busy, out, 1: high during initialisation; requests are ignored while busy=1.
- err, out, 1: one-cycle pulse for an out-of-range request.

## Operation

State machine with two states, INIT and RUN:
- reset=1 forces INIT, clears the init counter to 0 and flushes the read pipeline.
- INIT: writes 0 to word[cnt] each cycle and increments cnt. When cnt = DEPTH-1 the write is done and the next state is RUN. INIT lasts exactly DEPTH cycles after reset deasserts. busy=1 throughout.
- RUN: busy=0. Requests are sampled on every rising edge.

Write behaviour:
- A write occurs when wr_en=1 and addr < DEPTH.
- Only bytes with wstrb[i]=1 are updated.
- wstrb=0 with wr_en=1 is legal: no change, no error.

Read behaviour:
- A read is accepted when rd_en=1 and addr < DEPTH.
- Each accepted read produces exactly one rvalid pulse. Back-to-back reads are supported with full throughput.

Same-cycle read and write:
- wr_en=1 and rd_en=1 together perform both operations on addr.
- rdata follows RDW_MODE. For WRITE_FIRST, unstrobed bytes return the old contents.

Out-of-range requests:
- Any request with addr ≥ DEPTH is dropped: no write, no rvalid.
- err pulses high for one cycle, one cycle after the sample.

Requests while busy=1 are dropped silently, with no err.

## Timing

- Reset values: rdata=0, rvalid=0, err=0. busy=1 from the first cycle after reset is sampled high.
- Read latency: rd_en sampled at edge N gives rvalid=1 and rdata valid after edge N+RD_LAT.
- Write latency: data written at edge N is visible to a read sampled at edge N+1 (returned at N+1+RD_LAT). At edge N itself, RDW_MODE applies.
- rdata holds its last value while rvalid=0. It is cleared to 0 only by reset.
- Reset mid-read: all in-flight rvalid pulses are discarded and no stale rvalid appears after reset.
- Reset mid-INIT: INIT restarts from cnt=0.
- busy falls on the edge after the INIT write to DEPTH-1. The first request can be accepted on that same edge where busy is sampled low.
- No backpressure: the consumer must accept every rvalid pulse.

## Structure

- Package param_mem_pkg holds:
  - enum rdw_mode_e {READ_FIRST, WRITE_FIRST};
  - enum state_e {INIT, RUN};
  - constant MAX_RD_LAT=4;
  - a function that expands wstrb into a DATA_W-bit mask.
- One sub-module, param_mem_rd_pipe: an RD_LAT-deep shift register of {valid, data} with a synchronous flush. Stage 1 is loaded from the array read; the final stage drives rvalid and rdata.
- Storage is a plain array of DEPTH×DATA_W registers in the top level.

## Test plan

1. Reset then idle, defaults:
   - busy=1 for exactly 4 cycles, then 0.
   - Reads of addresses 0..3 return 0x00 with rvalid one cycle after each rd_en.
2. Write then read, default widths:
   - Write 0xA5 to address 2, then read address 2.
   - rdata=0xA5, rvalid one cycle after rd_en. Other addresses remain 0x00.
3. Byte strobes, DATA_W=32:
   - Write 0x11223344 with wstrb=4'hF, then write 0xAABBCCDD with wstrb=4'b0101 to the same address.
   - Read returns 0x11BB33DD.
4. Read-during-write:
   - Word holds 0x10; write 0x20 and read in the same cycle.
   - Returns 0x10 under READ_FIRST and 0x20 under WRITE_FIRST. The next read returns 0x20 in both modes.
5. Latency and out-of-range, RD_LAT=3, DEPTH=3, ADDR_W=2:
   - Back-to-back reads of addresses 0,1,2 give three consecutive rvalid pulses starting 3 cycles after the first rd_en.
   - A read of address 3 gives an err pulse and no rvalid.
6. Reset mid-operation, RD_LAT=3:
   - Assert reset 1 cycle after an rd_en: no rvalid appears.
   - busy returns to 1 and all words read 0 after INIT completes.

Source files
------------

// File: rtl/param_mem_pkg.sv
// Shared types and helpers for the parametrised single-port memory.
// Imported by the top level and available to anything driving it.
package param_mem_pkg;
    typedef enum logic {READ_FIRST, WRITE_FIRST} rdw_mode_e;
    typedef enum logic {INIT, RUN} state_e;

    localparam int MAX_RD_LAT = 4;
    localparam int MAX_DATA_W = 256;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    // Callers cast the strobe up to MAX_STRB_W and the result down to their width.
    function automatic logic [MAX_DATA_W-1:0] strb_to_mask(input logic [MAX_STRB_W-1:0] strb);
        logic [MAX_DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_STRB_W; i++) m[8*i +: 8] = {8{strb[i]}};
        return m;
    endfunction
endpackage

// File: rtl/param_mem_if.sv
// Request/response bundle between a memory master and param_mem.
interface param_mem_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0]   addr;
    logic                wr_en;
    logic                rd_en;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   rdata;
    logic                rvalid;
    logic                busy;
    logic                err;

    modport master (output addr, wr_en, rd_en, wstrb, wdata,
                    input  rdata, rvalid, busy, err);
    modport slave  (input  addr, wr_en, rd_en, wstrb, wdata,
                    output rdata, rvalid, busy, err);
endinterface

// File: rtl/param_mem_rd_pipe.sv
// RD_LAT-deep {valid, data} read-return pipeline with synchronous flush.
// Data stages advance only alongside a valid, so the output word holds between pulses.
module param_mem_rd_pipe #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              i_flush,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_data
);
    logic [RD_LAT-1:0]             r_vld_pipe;
    logic [RD_LAT-1:0][DATA_W-1:0] r_dat_pipe;

    always_ff @(posedge clk) begin
        if (i_flush) begin
            r_vld_pipe <= '0;
            r_dat_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= i_vld;
            if (i_vld) r_dat_pipe[0] <= i_data;
            for (int k = 1; k < RD_LAT; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                if (r_vld_pipe[k-1]) r_dat_pipe[k] <= r_dat_pipe[k-1];
            end
        end
    end

    assign o_vld  = r_vld_pipe[RD_LAT-1];
    assign o_data = r_dat_pipe[RD_LAT-1];
endmodule

// File: rtl/param_mem.sv
// Parametrised single-port synchronous memory with byte strobes, selectable
// read-during-write behaviour, out-of-range error pulse and zeroing INIT after reset.
module param_mem
    import param_mem_pkg::*;
#(
    parameter int        ADDR_W   = 2,
    parameter int        DATA_W   = 8,
    parameter int        DEPTH    = 4,
    parameter int        RD_LAT   = 1,
    parameter rdw_mode_e RDW_MODE = READ_FIRST
) (
    input  logic        clk,
    input  logic        reset,
    param_mem_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_err;

    logic              w_run, w_in_rng, w_wr, w_rd, w_init_wr;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_mask, w_old, w_new, w_rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_init_wr   = 1'b0;
        if (r_state == INIT) begin
            w_init_wr = 1'b1;
            if (r_cnt == IDX_W'(DEPTH - 1)) begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    assign w_run    = (r_state == RUN);
    assign w_in_rng = ({1'b0, bus.addr} < (ADDR_W + 1)'(DEPTH));
    assign w_idx    = bus.addr[IDX_W-1:0];
    assign w_wr     = w_run & bus.wr_en & w_in_rng;
    assign w_rd     = w_run & bus.rd_en & w_in_rng;

    assign w_mask    = DATA_W'(strb_to_mask(MAX_STRB_W'(bus.wstrb)));
    assign w_old     = r_mem[w_idx];
    assign w_new     = (w_old & ~w_mask) | (bus.wdata & w_mask);
    // WRITE_FIRST forwards the merged word so unstrobed bytes still show old contents.
    assign w_rd_data = (RDW_MODE == WRITE_FIRST && w_wr) ? w_new : w_old;

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_init_wr)  r_mem[r_cnt] <= '0;
            else if (w_wr)  r_mem[w_idx] <= w_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_err <= 1'b0;
        else       r_err <= w_run & (bus.wr_en | bus.rd_en) & ~w_in_rng;
    end

    param_mem_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_rd_pipe (
        .clk     (clk),
        .i_flush (reset),
        .i_vld   (w_rd),
        .i_data  (w_rd_data),
        .o_vld   (bus.rvalid),
        .o_data  (bus.rdata)
    );

    assign bus.busy = ~w_run;
    assign bus.err  = r_err;
endmodule

// File: tb/tb_param_mem.sv
// Two configurations side by side: A = 8-bit/4 words/RD_LAT 1/READ_FIRST,
// B = 32-bit/3 words/RD_LAT 3/WRITE_FIRST, each tracked by a word-level model.
module tb_param_mem;
    import param_mem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    param_mem_if #(.ADDR_W(2), .DATA_W(8))  ifa ();
    param_mem_if #(.ADDR_W(2), .DATA_W(32)) ifb ();

    param_mem #(.ADDR_W(2), .DATA_W(8), .DEPTH(4), .RD_LAT(1), .RDW_MODE(READ_FIRST))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));
    param_mem #(.ADDR_W(2), .DATA_W(32), .DEPTH(3), .RD_LAT(3), .RDW_MODE(WRITE_FIRST))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));

    int dep[2] = '{4, 3};
    int lat[2] = '{1, 3};
    bit wf[2]  = '{1'b0, 1'b1};

    typedef struct { int d; int due; logic [31:0] data; } rd_t;
    rd_t q[$];
    logic [31:0] mem [2][4];
    int          init_left[2];
    logic        e_busy[2], e_err[2], e_rvalid[2];
    logic [31:0] e_rdata[2];
    int cyc = 0;
    int n_chk = 0, n_fail = 0;

    function automatic logic [34:0] obs(int d);
        if (d == 0) return {ifa.busy, ifa.err, ifa.rvalid, 24'h0, ifa.rdata};
        return {ifb.busy, ifb.err, ifb.rvalid, ifb.rdata};
    endfunction

    function automatic logic [34:0] expv(int d);
        return {e_busy[d], e_err[d], e_rvalid[d], e_rdata[d]};
    endfunction

    task automatic drive(int d, logic [1:0] a, logic wr, logic rd, logic [3:0] st, logic [31:0] wd);
        if (d == 0) begin
            ifa.addr = a; ifa.wr_en = wr; ifa.rd_en = rd; ifa.wstrb = st[0]; ifa.wdata = wd[7:0];
        end else begin
            ifb.addr = a; ifb.wr_en = wr; ifb.rd_en = rd; ifb.wstrb = st; ifb.wdata = wd;
        end
    endtask

    task automatic idle_all();
        drive(0, 2'd0, 1'b0, 1'b0, 4'h0, 32'h0);
        drive(1, 2'd0, 1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    // Advance the reference model by one edge using the inputs now on the buses, then clock.
    task automatic tick();
        for (int d = 0; d < 2; d++) begin
            logic [1:0]  a;
            logic        wr, rd;
            logic [3:0]  st;
            logic [31:0] wd, old, nw, m;
            int          idx;
            if (d == 0) begin
                a = ifa.addr; wr = ifa.wr_en; rd = ifa.rd_en; st = {3'b0, ifa.wstrb}; wd = {24'h0, ifa.wdata};
            end else begin
                a = ifb.addr; wr = ifb.wr_en; rd = ifb.rd_en; st = ifb.wstrb; wd = ifb.wdata;
            end
            if (reset) begin
                init_left[d] = dep[d];
                for (int i = q.size() - 1; i >= 0; i--) if (q[i].d == d) q.delete(i);
                e_rdata[d] = 32'h0; e_rvalid[d] = 1'b0; e_err[d] = 1'b0;
            end else begin
                e_err[d] = 1'b0;
                if (init_left[d] > 0) begin
                    init_left[d]--;
                    if (init_left[d] == 0) for (int k = 0; k < 4; k++) mem[d][k] = 32'h0;
                end else if ((wr || rd) && int'(a) >= dep[d]) begin
                    e_err[d] = 1'b1;
                end else begin
                    old = mem[d][a];
                    m = 32'h0;
                    for (int b = 0; b < 4; b++) if (st[b]) m[8*b +: 8] = 8'hFF;
                    nw = (old & ~m) | (wd & m);
                    if (rd) q.push_back('{d, cyc + lat[d] - 1, (wf[d] && wr) ? nw : old});
                    if (wr) mem[d][a] = nw;
                end
                e_rvalid[d] = 1'b0;
                idx = -1;
                for (int i = 0; i < q.size(); i++) if (q[i].d == d) begin idx = i; break; end
                if (idx >= 0 && q[idx].due == cyc) begin
                    e_rvalid[d] = 1'b1;
                    e_rdata[d]  = q[idx].data;
                    q.delete(idx);
                end
            end
            e_busy[d] = (init_left[d] > 0);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        int ba, bb;
        reset = 1'b1; idle_all();
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (obs(d) !== expv(d)) begin n_fail++; $display("FAIL reset_model dut%0d: got %h want %h", d, obs(d), expv(d)); end
        end
        n_chk++;
        if ({ifa.busy, ifa.rvalid, ifa.err, ifa.rdata, ifb.busy, ifb.rvalid, ifb.err, ifb.rdata} !== {3'b100, 8'h0, 3'b100, 32'h0}) begin
            n_fail++; $display("FAIL reset_values: a busy/rv/err/rd=%b%b%b %h b=%b%b%b %h want 100 0",
                               ifa.busy, ifa.rvalid, ifa.err, ifa.rdata, ifb.busy, ifb.rvalid, ifb.err, ifb.rdata);
        end
        ba = 1; bb = 1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            ba += int'(ifa.busy); bb += int'(ifb.busy);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs(d) !== expv(d)) begin n_fail++; $display("FAIL init_model dut%0d cyc %0d: got %h want %h", d, cyc, obs(d), expv(d)); end
            end
        end
        n_chk++;
        if (ba != 4 || bb != 3) begin n_fail++; $display("FAIL busy_len: got a=%0d b=%0d want a=4 b=3", ba, bb); end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(0, 2'(i), 1'b0, 1'b1, 4'h0, 32'h0); else idle_all();
            tick();
            n_chk++;
            if (obs(0) !== expv(0)) begin n_fail++; $display("FAIL zero_read_model cyc %0d: got %h want %h", cyc, obs(0), expv(0)); end
            if (i < 4) begin
                n_chk++;
                if (ifa.rvalid !== 1'b1 || ifa.rdata !== 8'h00) begin
                    n_fail++; $display("FAIL zero_read addr %0d: got rv=%b rd=%h want rv=1 rd=00", i, ifa.rvalid, ifa.rdata);
                end
            end
        end
    endtask

    task automatic test_write_read();
        logic [1:0] ad[4] = '{2'd2, 2'd0, 2'd1, 2'd3};
        logic [7:0] ex[4] = '{8'hA5, 8'h00, 8'h00, 8'h00};
        drive(0, 2'd2, 1'b1, 1'b0, 4'h1, 32'hA5);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(0, ad[i], 1'b0, 1'b1, 4'h0, 32'h0); else idle_all();
            tick();
            n_chk++;
            if (obs(0) !== expv(0)) begin n_fail++; $display("FAIL wr_rd_model cyc %0d: got %h want %h", cyc, obs(0), expv(0)); end
            if (i < 4) begin
                n_chk++;
                if (ifa.rvalid !== 1'b1 || ifa.rdata !== ex[i]) begin
                    n_fail++; $display("FAIL wr_rd addr %0d: got rv=%b rd=%h want rv=1 rd=%h", ad[i], ifa.rvalid, ifa.rdata, ex[i]);
                end
            end
        end
    endtask

    task automatic test_strobes();
        drive(1, 2'd1, 1'b1, 1'b0, 4'hF, 32'h11223344); tick();
        drive(1, 2'd1, 1'b1, 1'b0, 4'b0101, 32'hAABBCCDD); tick();
        drive(1, 2'd1, 1'b0, 1'b1, 4'h0, 32'h0); tick();
        idle_all();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (obs(1) !== expv(1)) begin n_fail++; $display("FAIL strb_model cyc %0d: got %h want %h", cyc, obs(1), expv(1)); end
            if (i == 1) begin
                n_chk++;
                if (ifb.rvalid !== 1'b1 || ifb.rdata !== 32'h11BB33DD) begin
                    n_fail++; $display("FAIL strb_merge: got rv=%b rd=%h want rv=1 rd=11bb33dd", ifb.rvalid, ifb.rdata);
                end
            end
        end
    endtask

    task automatic test_rdw();
        logic [31:0] ga[$], gb[$];
        drive(0, 2'd1, 1'b1, 1'b0, 4'h1, 32'h10);
        drive(1, 2'd0, 1'b1, 1'b0, 4'hF, 32'h10);
        tick();
        drive(0, 2'd1, 1'b1, 1'b1, 4'h1, 32'h20);
        drive(1, 2'd0, 1'b1, 1'b1, 4'hF, 32'h20);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) begin
                drive(0, 2'd1, 1'b0, 1'b1, 4'h0, 32'h0);
                drive(1, 2'd0, 1'b0, 1'b1, 4'h0, 32'h0);
            end else idle_all();
            if (ifa.rvalid === 1'b1) ga.push_back({24'h0, ifa.rdata});
            if (ifb.rvalid === 1'b1) gb.push_back(ifb.rdata);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs(d) !== expv(d)) begin n_fail++; $display("FAIL rdw_model dut%0d cyc %0d: got %h want %h", d, cyc, obs(d), expv(d)); end
            end
        end
        n_chk++;
        if (ga.size() != 2 || ga[0] !== 32'h10 || ga[1] !== 32'h20) begin
            n_fail++; $display("FAIL rdw_read_first: got %0d beats %h %h want 2 beats 10 20", ga.size(), ga[0], ga[1]);
        end
        n_chk++;
        if (gb.size() != 2 || gb[0] !== 32'h20 || gb[1] !== 32'h20) begin
            n_fail++; $display("FAIL rdw_write_first: got %0d beats %h %h want 2 beats 20 20", gb.size(), gb[0], gb[1]);
        end
    endtask

    task automatic test_latency_oor();
        logic [7:0] vb, eb;
        vb = '0; eb = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) drive(1, 2'(i), 1'b0, 1'b1, 4'h0, 32'h0); else idle_all();
            tick();
            vb[i] = ifb.rvalid; eb[i] = ifb.err;
            n_chk++;
            if (obs(1) !== expv(1)) begin n_fail++; $display("FAIL lat_model cyc %0d: got %h want %h", cyc, obs(1), expv(1)); end
        end
        n_chk++;
        if (vb !== 8'b0001_1100 || eb !== 8'b0000_1000) begin
            n_fail++; $display("FAIL lat_oor: got rvalid=%b err=%b want rvalid=00011100 err=00001000", vb, eb);
        end
    endtask

    task automatic test_reset_mid();
        logic any_v;
        int   ba, bb, nv;
        drive(1, 2'd2, 1'b1, 1'b0, 4'hF, 32'hDEADBEEF); tick();
        drive(1, 2'd2, 1'b0, 1'b1, 4'h0, 32'h0); tick();
        idle_all(); reset = 1'b1; tick();
        n_chk++;
        if (ifb.busy !== 1'b1 || ifb.rvalid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_busy: got busy=%b rv=%b want busy=1 rv=0", ifb.busy, ifb.rvalid);
        end
        reset = 1'b0; tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        any_v = 1'b0; ba = 0; bb = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            any_v |= ifb.rvalid;
            ba += int'(ifa.busy); bb += int'(ifb.busy);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs(d) !== expv(d)) begin n_fail++; $display("FAIL mid_model dut%0d cyc %0d: got %h want %h", d, cyc, obs(d), expv(d)); end
            end
        end
        n_chk++;
        if (any_v !== 1'b0) begin n_fail++; $display("FAIL stale_rvalid: got rvalid=%b after reset want 0", any_v); end
        n_chk++;
        if (ba != 3 || bb != 2) begin n_fail++; $display("FAIL init_restart: got busy a=%0d b=%0d want a=3 b=2", ba, bb); end
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive(1, 2'(i), 1'b0, 1'b1, 4'h0, 32'h0); else idle_all();
            tick();
            if (ifb.rvalid === 1'b1) begin
                nv++;
                n_chk++;
                if (ifb.rdata !== 32'h0) begin n_fail++; $display("FAIL post_init_zero: got %h want 00000000", ifb.rdata); end
            end
        end
        n_chk++;
        if (nv != 3) begin n_fail++; $display("FAIL post_init_count: got %0d reads want 3", nv); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 149) == 0);
            for (int d = 0; d < 2; d++)
                drive(d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), $urandom);
            tick();
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (obs(d) !== expv(d)) begin n_fail++; $display("FAIL random dut%0d cyc %0d: got %h want %h", d, cyc, obs(d), expv(d)); end
            end
        end
        reset = 1'b0; idle_all();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_write_read();
        test_strobes();
        test_rdw();
        test_latency_oor();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
